logic_pipe_stage: RTL and testbench

Registered bitwise logic stage that consumes operand pairs, applies a selected bitwise operation (AND/OR/XOR/NAND), and presents the result one cycle later with a valid/ready handshake. It sits directly downstream of the combinational gate primitives, such as the parameterized AND gate, and feeds the ALU result path. A two-entry skid buffer gives full throughput under backpressure with no combinational ready path. It also produces a zero flag and a transaction counter for the result bus.

---
 rtl/logic_pipe_stage.sv | 134 +++++++++++++
 tb/tb_logic_pipe_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage
//   Registered bitwise logic stage (AND/OR/XOR/NAND) with a valid/ready
//   handshake on each side. A main output register plus one skid register
//   give full throughput under backpressure. There is no combinational path
//   from out_ready to in_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream offers an operand pair
//   in_ready   stage can accept an operand pair
//   a, b       operands (WIDTH bits)
//   op         00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid  y/zero hold a valid result
//   out_ready  downstream consumes the result
//   y          registered result
//   zero       1 when y == 0, registered with y
//   txn_count  completed output handshakes, wraps at 256
module logic_pipe_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [7:0]       txn_count
);

  // State encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] main_y, skid_y;
  logic             main_zero, skid_zero;
  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             in_fire, out_fire;
  logic             load_main, load_skid, promote_skid;

  always_comb begin
    result = '0;
    unique case (op)
      2'b00: result = a & b;
      2'b01: result = a | b;
      2'b10: result = a ^ b;
      2'b11: result = ~(a & b);
      default: result = '0;
    endcase
  end

  assign result_zero = (result == '0);

  assign in_ready  = (state != FULL) && !rst;
  assign out_valid = state[0];
  assign y         = main_y;
  assign zero      = main_zero;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    promote_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main  = 1'b1;
          state_next = ONE;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (out_fire) begin
          promote_skid = 1'b1;
          state_next   = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_y    <= '0;
      main_zero <= 1'b0;
      skid_y    <= '0;
      skid_zero <= 1'b0;
      txn_count <= '0;
    end else begin
      state <= state_next;
      if (load_main) begin
        main_y    <= result;
        main_zero <= result_zero;
      end else if (promote_skid) begin
        main_y    <= skid_y;
        main_zero <= skid_zero;
      end
      if (load_skid) begin
        skid_y    <= result;
        skid_zero <= result_zero;
      end
      if (out_fire) begin
        txn_count <= txn_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_logic_pipe_stage.sv
module tb_logic_pipe_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;
  logic       zero;
  logic [7:0] txn_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_pipe_stage #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .txn_count (txn_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 4'b1111; b = 4'b1111; op = 2'b00; out_ready = 1'b1;

    // Reset held 3 cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_txn", 32'(txn_count), 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("post_rst_nothing_captured", 32'(out_valid), 32'd0);

    // Operations, out_ready=1.
    in_valid = 1'b1; a = 4'b1010; b = 4'b1100;
    op = 2'b00; cyc();
    chk("op_and_y", 32'(y), 32'b1000);
    chk("op_and_valid", 32'(out_valid), 32'd1);
    chk("op_and_zero", 32'(zero), 32'd0);
    op = 2'b01; cyc();
    chk("op_or_y", 32'(y), 32'b1110);
    op = 2'b10; cyc();
    chk("op_xor_y", 32'(y), 32'b0110);
    op = 2'b11; cyc();
    chk("op_nand_y", 32'(y), 32'b0111);
    chk("op_nand_zero", 32'(zero), 32'd0);
    a = 4'b0000; b = 4'b1111; op = 2'b00; cyc();
    chk("op_zero_y", 32'(y), 32'b0000);
    chk("op_zero_flag", 32'(zero), 32'd1);
    chk("op_zero_valid", 32'(out_valid), 32'd1);
    chk("op_txn_mid", 32'(txn_count), 32'd4);
    in_valid = 1'b0; cyc();
    chk("op_txn_end", 32'(txn_count), 32'd5);
    chk("op_drained", 32'(out_valid), 32'd0);

    // Fresh reset so the streaming count starts at 0.
    rst = 1'b1; cyc();
    chk("rst2_txn", 32'(txn_count), 32'd0);
    rst = 1'b0; cyc();

    // Streaming: XOR with b=0 passes a through, results 1..5.
    in_valid = 1'b1; op = 2'b10; b = 4'b0000;
    for (int i = 1; i <= 5; i++) begin
      a = 4'(i);
      cyc();
      chk("stream_y", 32'(y), 32'(i));
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0; cyc();
    chk("stream_txn", 32'(txn_count), 32'd5);
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Backpressure.
    out_ready = 1'b0; in_valid = 1'b1; op = 2'b00;
    a = 4'b1111; b = 4'b1111; cyc();
    chk("bp_first_y", 32'(y), 32'b1111);
    chk("bp_first_in_ready", 32'(in_ready), 32'd1);
    a = 4'b1010; b = 4'b1100; cyc();
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_full_y", 32'(y), 32'b1111);
    a = 4'b0101; b = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("bp_hold_y", 32'(y), 32'b1111);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_zero", 32'(zero), 32'd0);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_txn", 32'(txn_count), 32'd5);
    end
    out_ready = 1'b1; cyc();
    chk("bp_rec_y", 32'(y), 32'b1000);
    chk("bp_rec_in_ready", 32'(in_ready), 32'd1);
    chk("bp_rec_txn", 32'(txn_count), 32'd6);
    cyc();
    chk("bp_third_y", 32'(y), 32'b0000);
    chk("bp_third_zero", 32'(zero), 32'd1);
    chk("bp_third_txn", 32'(txn_count), 32'd7);
    in_valid = 1'b0; cyc();
    chk("bp_txn_end", 32'(txn_count), 32'd8);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Wrap: 248 more handshakes take the count from 8 to 256 -> 0.
    in_valid = 1'b1; a = 4'b0001; b = 4'b0001;
    for (int i = 0; i < 248; i++) cyc();
    chk("wrap_255", 32'(txn_count), 32'd255);
    in_valid = 1'b0; cyc();
    chk("wrap_0", 32'(txn_count), 32'd0);
    in_valid = 1'b1; cyc();
    in_valid = 1'b0; cyc();
    chk("wrap_1", 32'(txn_count), 32'd1);

    // Mid-operation reset from FULL.
    out_ready = 1'b0; in_valid = 1'b1; op = 2'b01;
    a = 4'b1111; b = 4'b0000; cyc();
    a = 4'b0011; cyc();
    chk("mid_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1; cyc();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_txn", 32'(txn_count), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mid_after_valid", 32'(out_valid), 32'd0);
      chk("mid_after_y", 32'(y), 32'd0);
      chk("mid_after_txn", 32'(txn_count), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
